motor_pwm_driver: RTL and testbench
===================================

Name: motor_pwm_driver

Overview:
Downstream stage of the line-follower FSM. Takes the FSM's per-motor direction bits and a 5-bit duty request, then produces PWM-gated H-bridge drive signals. It enforces break-before-make dead time on any direction change and flags illegal commands. It replaces the unused PWM stub in the FSM top with a self-contained timing block.

Parameters:
PRESCALE, 4, clocks per PWM tick (>=1)
PERIOD, 32, ticks per PWM period (>=32, so every duty value is below it)
DEAD_TIME, 8, clocks both bridge legs are held low on a direction change (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
en  input  1  drive enable; low forces coast
cmd  input  4  {a_fwd, a_rev, b_fwd, b_rev} from the FSM
duty  input  5  requested duty, 0..31
out  output  4  {a_fwd, a_rev, b_fwd, b_rev} to the H-bridge, registered
period_start  output  1  one-clock pulse on the first clock of each PWM period, registered
fault  output  1  sticky illegal-command flag

Behaviour:
- Reset values: out=0, period_start=0, fault=0, prescaler=0, pcnt=0, duty_q=0, both channels IDLE.
- Reset mid-operation: out=0 from the next edge with no dead-time sequence. Everything returns to reset values.
- Prescaler counts 0..PRESCALE-1. tick is asserted when prescaler==PRESCALE-1, then the prescaler wraps to 0.
- pcnt counts 0..PERIOD-1 and advances on tick, wrapping to 0.
- When tick is high and pcnt==PERIOD-1: duty_q<=duty and period_start<=1 on that edge. Otherwise period_start<=0.
- Mid-period duty changes are ignored until the next wrap.
- pwm_on = (duty_q==31) ? 1 : (pcnt < duty_q). duty 0 gives a constant 0; duty 31 gives a constant 1.
- Each motor channel (A and B) is decoded independently from its cmd pair:
  - 00 = COAST
  - 10 = FWD
  - 01 = REV
  - 11 = illegal, treated as COAST, and fault<=1. fault clears only on reset.
- en=0 makes every request COAST.
- Channel FSM (states IDLE, DRIVE, DEAD; registers dir and dcnt):
  - IDLE: on request FWD/REV, go to DRIVE with dir=request. No dead time is needed from coast.
  - DRIVE: while request==dir, stay. On any other request (COAST, opposite direction, illegal), go to DEAD with dcnt=DEAD_TIME-1.
  - DEAD: dcnt decrements each clock. When dcnt==0, exit: request COAST goes to IDLE; request FWD/REV goes to DRIVE with dir=request. Requests changing during DEAD are sampled only at exit.
  - DEAD_TIME=1 gives exactly one all-low clock.
- Outputs use registered next-state values (one clock of latency):
  - out leg for dir = (next state==DRIVE) & pwm_on(next pcnt/duty_q).
  - The opposite leg is always 0.
  - IDLE/DEAD drive both legs 0.
  - fwd and rev of the same channel are never both 1 in any cycle.
- A cmd change at edge N is visible on out at edge N+1. A reversal gives DEAD_TIME all-low clocks, then the new leg.

Optional Feature:
SOFT_START_EN
- Defined: add register duty_eff (reset 0). At each period wrap, duty_eff steps by 1 toward duty_q, and pwm_on uses duty_eff instead of duty_q. While both channels are IDLE, duty_eff is held at 0.
- Undefined: duty_eff is absent and pwm_on uses duty_q directly, as described above.

Test Plan:
1. Defaults, reset, en=1, duty=16, cmd=1000 -> after the first period_start, out[3] is high 64 and low 64 of every 128 clocks; out[2:0]=0; period_start pulses every 128 clocks.
2. Duty extremes: duty=0 -> out=0 constantly. duty=31 -> out[3] constantly 1 after the first wrap. Change duty 16->8 at pcnt=5 -> the current period keeps 64 high clocks, the next has 32.
3. Reversal: cmd 1000->0100 with duty=31 -> out=0000 for exactly 8 clocks, then out=0100. Never 1100.
4. Illegal: cmd=0011 -> fault=1, out[1:0]=0; channel A unaffected. cmd back to 0010 -> fault stays 1 until reset.
5. en drop: en 1->0 while driving -> 8 all-low clocks (DEAD), then IDLE. en 0->1 with cmd=1000 -> drive resumes without dead time.
6. Reset mid-DEAD plus SOFT_START_EN: assert reset during DEAD -> out=0 the next clock and duty_q=0. With the macro defined and duty=4 -> high time per period goes 0,4,8,12,16,16 clocks over successive periods.

Source files
------------

// File: rtl/motor_pwm_driver.sv
// PWM-gated H-bridge driver with per-channel break-before-make dead time.
// Optional SOFT_START_EN ramps the effective duty by one step per period.
module motor_pwm_driver #(
  parameter int PRESCALE  = 4,
  parameter int PERIOD    = 32,
  parameter int DEAD_TIME = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] cmd,
  input  logic [4:0] duty,
  output logic [3:0] out,
  output logic       period_start,
  output logic       fault
);

  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int PCW = $clog2(PERIOD);
  localparam int DCW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DEAD  = 2'd2
  } ch_state_e;

  typedef enum logic [1:0] {
    REQ_COAST = 2'd0,
    REQ_FWD   = 2'd1,
    REQ_REV   = 2'd2
  } req_e;

  logic [PSW-1:0] presc_q, presc_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic [4:0]     duty_q, duty_d;
  logic           period_start_q, period_start_d;
  logic           fault_q, fault_d;
  logic [3:0]     out_q, out_d;

  ch_state_e      state_q [2];
  ch_state_e      state_d [2];
  logic           dir_q   [2];
  logic           dir_d   [2];
  logic [DCW-1:0] dcnt_q  [2];
  logic [DCW-1:0] dcnt_d  [2];

  logic       tick;
  logic       wrap;
  logic       pwm_on;
  logic [4:0] duty_use;
  req_e       req [2];
  logic [1:0] pair [2];

`ifdef SOFT_START_EN
  logic [4:0] duty_eff_q, duty_eff_d;
`endif

  always_comb begin
    tick   = (presc_q == PSW'(PRESCALE - 1));
    wrap   = tick && (pcnt_q == PCW'(PERIOD - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
    pcnt_d  = pcnt_q;
    if (tick) begin
      pcnt_d = wrap ? '0 : pcnt_q + 1'b1;
    end
    duty_d         = wrap ? duty : duty_q;
    period_start_d = wrap;
    fault_d        = fault_q;

    pair[0] = cmd[3:2];
    pair[1] = cmd[1:0];
    for (int i = 0; i < 2; i++) begin
      req[i] = REQ_COAST;
      unique case (1'b1)
        (pair[i] == 2'b11): fault_d = 1'b1;
        (pair[i] == 2'b10): req[i] = REQ_FWD;
        (pair[i] == 2'b01): req[i] = REQ_REV;
        default:            req[i] = REQ_COAST;
      endcase
      if (!en) begin
        req[i] = REQ_COAST;
      end
    end

    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      dir_d[i]   = dir_q[i];
      dcnt_d[i]  = dcnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (req[i] != REQ_COAST) begin
            state_d[i] = DRIVE;
            dir_d[i]   = (req[i] == REQ_REV);
          end
        end
        DRIVE: begin
          if (req[i] != (dir_q[i] ? REQ_REV : REQ_FWD)) begin
            state_d[i] = DEAD;
            dcnt_d[i]  = DCW'(DEAD_TIME - 1);
          end
        end
        DEAD: begin
          if (dcnt_q[i] == '0) begin
            if (req[i] == REQ_COAST) begin
              state_d[i] = IDLE;
            end else begin
              state_d[i] = DRIVE;
              dir_d[i]   = (req[i] == REQ_REV);
            end
          end else begin
            dcnt_d[i] = dcnt_q[i] - 1'b1;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end

`ifdef SOFT_START_EN
    duty_eff_d = duty_eff_q;
    if (state_q[0] == IDLE && state_q[1] == IDLE) begin
      duty_eff_d = '0;
    end else if (wrap) begin
      if (duty_eff_q < duty_d) begin
        duty_eff_d = duty_eff_q + 1'b1;
      end else if (duty_eff_q > duty_d) begin
        duty_eff_d = duty_eff_q - 1'b1;
      end
    end
    duty_use = duty_eff_d;
`else
    duty_use = duty_d;
`endif

    pwm_on = (duty_use == 5'd31) ? 1'b1 : (pcnt_d < PCW'(duty_use));

    // Output follows the next state so a cmd edge shows one clock later.
    out_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (state_d[i] == DRIVE && pwm_on) begin
        out_d[3 - 2 * i] = !dir_d[i];
        out_d[2 - 2 * i] = dir_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q        <= '0;
      pcnt_q         <= '0;
      duty_q         <= '0;
      period_start_q <= 1'b0;
      fault_q        <= 1'b0;
      out_q          <= '0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        dir_q[i]   <= 1'b0;
        dcnt_q[i]  <= '0;
      end
`ifdef SOFT_START_EN
      duty_eff_q <= '0;
`endif
    end else begin
      presc_q        <= presc_d;
      pcnt_q         <= pcnt_d;
      duty_q         <= duty_d;
      period_start_q <= period_start_d;
      fault_q        <= fault_d;
      out_q          <= out_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        dir_q[i]   <= dir_d[i];
        dcnt_q[i]  <= dcnt_d[i];
      end
`ifdef SOFT_START_EN
      duty_eff_q <= duty_eff_d;
`endif
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Scoreboard bench for motor_pwm_driver against a time-based reference model.
module tb_motor_pwm_driver;

  localparam int PRESCALE  = 4;
  localparam int PERIOD    = 32;
  localparam int DEAD_TIME = 8;
  localparam int PCLK      = PRESCALE * PERIOD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [3:0] cmd = 4'b0;
  logic [4:0] duty = 5'd0;
  logic [3:0] out;
  logic       period_start;
  logic       fault;

  motor_pwm_driver #(
    .PRESCALE (PRESCALE),
    .PERIOD   (PERIOD),
    .DEAD_TIME(DEAD_TIME)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .cmd         (cmd),
    .duty        (duty),
    .out         (out),
    .period_start(period_start),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] o;
    logic       ps;
    logic       f;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: edges since reset, latched duty, per-channel drive
  // (0 none, 1 fwd, 2 rev) and remaining all-low clocks.
  int   n_edges;
  int   mduty;
  bit   mfault;
  int   act [2];
  int   dl  [2];

  task automatic check(input string nm, input logic [7:0] a, input logic [7:0] r);
    n_cmp++;
    if (a !== r) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, a, r);
    end
  endtask

  task automatic step(input logic r, input logic e_in, input logic [3:0] c, input logic [4:0] d);
    exp_t x;
    int   pc;
    bit   on;
    int   rq;
    logic [1:0] pr;
    @(negedge clk);
    reset = r;
    en    = e_in;
    cmd   = c;
    duty  = d;
    x     = '0;
    if (r) begin
      n_edges = 0;
      mduty   = 0;
      mfault  = 0;
      act     = '{0, 0};
      dl      = '{0, 0};
    end else begin
      n_edges++;
      x.ps = (n_edges % PCLK) == 0;
      if (x.ps) mduty = d;
      pc = (n_edges / PRESCALE) % PERIOD;
      on = (mduty == 31) || (pc < mduty);
      for (int ch = 0; ch < 2; ch++) begin
        pr = (ch == 0) ? c[3:2] : c[1:0];
        if (pr == 2'b11) mfault = 1;
        rq = !e_in ? 0 : (pr == 2'b10) ? 1 : (pr == 2'b01) ? 2 : 0;
        if (dl[ch] > 0) begin
          dl[ch]--;
          if (dl[ch] == 0) act[ch] = rq;
        end else if (act[ch] == 0) begin
          act[ch] = rq;
        end else if (act[ch] != rq) begin
          act[ch] = 0;
          dl[ch]  = DEAD_TIME;
        end
        if (on && act[ch] == 1) x.o[3 - 2 * ch] = 1'b1;
        if (on && act[ch] == 2) x.o[2 - 2 * ch] = 1'b1;
      end
      x.f = mfault;
    end
    sb.push_back(x);
  endtask

  task automatic seg(input logic r, input logic e_in, input logic [3:0] c,
                     input logic [4:0] d, input int len);
    for (int k = 0; k < len; k++) step(r, e_in, c, d);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out", {4'b0, out}, {4'b0, e.o});
        check("period_start", {7'b0, period_start}, {7'b0, e.ps});
        check("fault", {7'b0, fault}, {7'b0, e.f});
      end
    end
  end

  logic [3:0] cmd_tab [9];
  logic [3:0] rc;
  logic [4:0] rd;

  initial begin
    cmd_tab = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
                4'b1010, 4'b0101, 4'b1001, 4'b0110};
    seg(1, 0, 4'b0000, 5'd0, 3);
    seg(0, 1, 4'b1000, 5'd16, 400);
    seg(0, 1, 4'b1000, 5'd8, 20);
    seg(0, 1, 4'b1000, 5'd0, 300);
    seg(0, 1, 4'b1000, 5'd31, 300);
    seg(0, 1, 4'b0100, 5'd31, 40);
    seg(0, 1, 4'b0011, 5'd31, 30);
    seg(0, 1, 4'b0010, 5'd20, 200);
    seg(0, 0, 4'b0010, 5'd20, 20);
    seg(0, 1, 4'b1000, 5'd20, 150);
    seg(0, 1, 4'b0100, 5'd20, 3);
    seg(1, 1, 4'b0100, 5'd20, 1);
    seg(0, 1, 4'b0100, 5'd20, 200);
    for (int s = 0; s < 70; s++) begin
      rc = cmd_tab[$urandom_range(0, 8)];
      if ($urandom_range(0, 19) == 0) rc = 4'b1100 | 4'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       rd = 5'd0;
        1:       rd = 5'd31;
        default: rd = 5'($urandom_range(0, 31));
      endcase
      if ($urandom_range(0, 24) == 0) seg(1, 1, rc, rd, $urandom_range(1, 3));
      seg(0, ($urandom_range(0, 7) != 0), rc, rd, $urandom_range(1, 260));
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
